// File: rtl/lut_pkg.sv
// Shared definitions for the lut_bank lookup table: FSM states, latency limits
// and the helper that locates a channel's slice inside a packed port.
package lut_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } lut_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 2;

  function automatic int chanLsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage

// File: rtl/lut_read_port.sv
// One registered read channel: address mux into the table, gated by ready,
// followed by an optional second output stage when LATENCY is 2.
module lut_read_port
  import lut_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_valid_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data1_q;
  logic              valid1_q;
  logic              accept;

  assign accept = req_valid_i && ready_i;

  // Data registers only load on a served request, so the output holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= accept;
      if (accept) begin
        data1_q <= mem_i[addr_i];
      end
    end
  end

  generate
    if (LATENCY > LATENCY_MIN) begin : g_lat2
      logic [DATA_W-1:0] data2_q;
      logic              valid2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data2_q  <= '0;
          valid2_q <= 1'b0;
        end else begin
          valid2_q <= valid1_q;
          if (valid1_q) begin
            data2_q <= data1_q;
          end
        end
      end

      assign data_o  = data2_q;
      assign valid_o = valid2_q;
    end else begin : g_lat1
      assign data_o  = data1_q;
      assign valid_o = valid1_q;
    end
  endgenerate

endmodule

// File: rtl/lut_bank.sv
// Runtime-reloadable lookup table with CHANNELS independent registered read
// ports, a post-reset clear sweep and a streamed full-table load.
module lut_bank
  import lut_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2,
  parameter int LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*ADDR_W-1:0] a,
  input  logic [CHANNELS-1:0]        req_valid,
  output logic [CHANNELS*DATA_W-1:0] qspo,
  output logic [CHANNELS-1:0]        q_valid,
  output logic                       ready,
  input  logic                       ld_start,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  output logic                       ld_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  lut_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ldDone_q, ldDone_d;
  logic              memWe;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ptrLast;

  assign ptrLast = (ptr_q == LAST_ADDR);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ldDone_d = 1'b0;
    memWe    = 1'b0;
    memWdata = '0;
    case (state_q)
      CLEAR: begin
        memWe = 1'b1;
        if (ptrLast) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          memWe    = 1'b1;
          memWdata = ld_data;
          if (ptrLast) begin
            state_d  = IDLE;
            ptr_d    = '0;
            ldDone_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      ldDone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ldDone_q <= ldDone_d;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[ptr_q] <= memWdata;
    end
  end

  // ready stays low through the ld_done cycle so the two never overlap.
  assign ready    = (state_q == IDLE) && !ldDone_q;
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = ldDone_q;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      lut_read_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
      ) u_port (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (a[chanLsb(c, ADDR_W) +: ADDR_W]),
        .req_valid_i(req_valid[c]),
        .ready_i    (ready),
        .mem_i      (mem),
        .data_o     (qspo[chanLsb(c, DATA_W) +: DATA_W]),
        .valid_o    (q_valid[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_lut_bank.sv
// Scoreboard bench for lut_bank: a LATENCY=1 and a LATENCY=2 instance share
// directed stimulus; a negedge monitor pops expected results per channel.
module tb_lut_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [1:0]  req_valid;
  logic        ld_start;
  logic [7:0]  ld_data;
  logic        ld_valid;

  logic [15:0] qspo1, qspo2;
  logic [1:0]  qv1, qv2;
  logic        rdy1, rdy2, ldr1, ldr2, ldd1, ldd2;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t qs [4][$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int doneCnt1 = 0, doneCyc1 = 0, doneCnt2 = 0, doneCyc2 = 0;

  lut_bank #(.ADDR_W(8), .DATA_W(8), .CHANNELS(2), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .req_valid(req_valid), .qspo(qspo1), .q_valid(qv1),
    .ready(rdy1), .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ldr1), .ld_done(ldd1)
  );

  lut_bank #(.ADDR_W(8), .DATA_W(8), .CHANNELS(2), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .req_valid(req_valid), .qspo(qspo2), .q_valid(qv2),
    .ready(rdy2), .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(ldr2), .ld_done(ldd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every presented result must match the oldest expectation and arrive on its due cycle.
  always @(negedge clk) begin
    logic       v;
    logic [7:0] d;
    exp_t       e;
    for (int k = 0; k < 4; k++) begin
      v = (k < 2) ? qv1[k % 2] : qv2[k % 2];
      d = (k < 2) ? qspo1[(k % 2) * 8 +: 8] : qspo2[(k % 2) * 8 +: 8];
      if (v) begin
        checks++;
        if (qs[k].size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedValid dut%0d ch%0d: got valid data=%h at cycle %0d, required no result",
                   k / 2 + 1, k % 2, d, cyc);
        end else begin
          e = qs[k].pop_front();
          if (d !== e.data || cyc != e.due) begin
            errors++;
            $display("[TB] FAIL lookup dut%0d ch%0d: got %h at cycle %0d, required %h at cycle %0d",
                     k / 2 + 1, k % 2, d, cyc, e.data, e.due);
          end
        end
      end else if (qs[k].size() > 0 && qs[k][0].due < cyc) begin
        checks++;
        errors++;
        e = qs[k].pop_front();
        $display("[TB] FAIL missingResult dut%0d ch%0d: got nothing by cycle %0d, required %h at cycle %0d",
                 k / 2 + 1, k % 2, cyc, e.data, e.due);
      end
    end
    if (ldd1) begin doneCnt1++; doneCyc1 = cyc; end
    if (ldd2) begin doneCnt2++; doneCyc2 = cyc; end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [7:0] addr, input logic [7:0] expData);
    exp_t e;
    a[ch * 8 +: 8] = addr;
    req_valid[ch]  = 1'b1;
    e.data = expData;
    e.due  = cyc + 1;
    qs[ch].push_back(e);
    e.due  = cyc + 2;
    qs[2 + ch].push_back(e);
  endtask

  task automatic drain();
    req_valid = 2'b00;
    repeat (3) tick();
  endtask

  task automatic resetAndWait();
    rst = 1'b1;
    #1;
    checkOutput("rstQspo1",   32'(qspo1), 32'h0);
    checkOutput("rstQspo2",   32'(qspo2), 32'h0);
    checkOutput("rstQValid1", 32'(qv1),   32'h0);
    checkOutput("rstQValid2", 32'(qv2),   32'h0);
    checkOutput("rstReady",   32'({rdy2, rdy1}), 32'h0);
    checkOutput("rstLdReady", 32'({ldr2, ldr1}), 32'h0);
    checkOutput("rstLdDone",  32'({ldd2, ldd1}), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) checkOutput("readyBeforeClearEnd", 32'({rdy2, rdy1}), 32'h0);
      if (i == 256) checkOutput("readyAfterClear",     32'({rdy2, rdy1}), 32'h3);
    end
  endtask

  // Streams words i^key; gaps inserts an idle cycle after each word and pokes ld_start mid-load.
  task automatic doLoad(input logic [7:0] key, input bit gaps, input int words, input bit holdReq);
    int start;
    int d1, d2;
    d1 = doneCnt1;
    d2 = doneCnt2;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    start = cyc;
    if (holdReq) begin
      a = {8'h10, 8'h03};
      req_valid = 2'b11;
    end else begin
      req_valid = 2'b00;
    end
    for (int i = 0; i < words; i++) begin
      ld_valid = 1'b1;
      ld_data  = i[7:0] ^ key;
      ld_start = gaps && (i == 50);
      tick();
      if (i >= 1 && i < words - 1) begin
        checkOutput("qValidInLoad1", 32'(qv1), 32'h0);
        checkOutput("qValidInLoad2", 32'(qv2), 32'h0);
      end
      if (gaps && i < words - 1) begin
        ld_valid = 1'b0;
        ld_start = 1'b0;
        tick();
      end
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    if (words == 256) begin
      checkOutput("ldDoneAtLast", 32'({ldd2, ldd1}), 32'h3);
      checkOutput("readyLowAtDone", 32'({rdy2, rdy1}), 32'h0);
      checkOutput("ldReadyDropped", 32'({ldr2, ldr1}), 32'h0);
      req_valid = 2'b00;
      tick();
      checkOutput("readyAfterDone", 32'({rdy2, rdy1}), 32'h3);
      checkOutput("ldDoneOnePulse", 32'({ldd2, ldd1}), 32'h0);
      checkOutput("ldDoneCount1", 32'(doneCnt1 - d1), 32'd1);
      checkOutput("ldDoneCount2", 32'(doneCnt2 - d2), 32'd1);
      checkOutput("ldDoneCycle1", 32'(doneCyc1 - start), gaps ? 32'd511 : 32'd256);
      checkOutput("ldDoneCycle2", 32'(doneCyc2 - start), gaps ? 32'd511 : 32'd256);
    end
  endtask

  initial begin
    rst       = 1'b0;
    a         = '0;
    req_valid = '0;
    ld_start  = 1'b0;
    ld_data   = '0;
    ld_valid  = 1'b0;
    #2;
    resetAndWait();

    // Freshly cleared table reads zero.
    applyStimulus(0, 8'hF0, 8'h00);
    applyStimulus(1, 8'h01, 8'h00);
    tick();
    drain();

    doLoad(8'hA5, 1'b0, 256, 1'b0);
    applyStimulus(0, 8'hF0, 8'h55);
    applyStimulus(1, 8'h0F, 8'hAA);
    tick();
    drain();
    checkOutput("qspoHold1", 32'(qspo1), 32'h0000AA55);
    checkOutput("qspoHold2", 32'(qspo2), 32'h0000AA55);

    // Load words offered outside LOAD must not be written.
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    repeat (3) tick();
    ld_valid = 1'b0;
    applyStimulus(0, 8'h00, 8'hA5);
    tick();
    drain();

    doLoad(8'hA5, 1'b1, 256, 1'b1);
    applyStimulus(0, 8'h03, 8'hA6);
    applyStimulus(1, 8'hFF, 8'h5A);
    tick();
    drain();

    // Request coinciding with ld_start sees the old table.
    applyStimulus(0, 8'h03, 8'hA6);
    doLoad(8'h3C, 1'b0, 256, 1'b0);
    applyStimulus(0, 8'h03, 8'h3F);
    applyStimulus(1, 8'h10, 8'h2C);
    tick();
    drain();

    doLoad(8'hA5, 1'b0, 100, 1'b0);
    resetAndWait();
    applyStimulus(0, 8'h10, 8'h00);
    applyStimulus(1, 8'hFF, 8'h00);
    tick();
    drain();

    for (int k = 0; k < 4; k++) begin
      checkOutput("queueEmpty", 32'(qs[k].size()), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
